alu4_seq: RTL and testbench
===========================

# alu4_seq

Register-file sequencer that sits directly upstream of the 4-bit combinational ALU (`alu4`). It accepts instructions over a valid/ready handshake and reads two operands from a 4-entry × 4-bit register file. It then drives the ALU's `a`/`b`/`opcode` inputs, captures the ALU's `x`/`y` outputs, and presents the result downstream. On the output handshake it writes `x` back into the register file and updates status flags.

## Interface
Parameters: none. Widths are fixed by the ALU (4-bit data, 4-bit opcode, 4 registers).

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: sequencer can accept an instruction.
- `in_op` in 4: ALU opcode, 0–15.
- `in_rd` in 2: destination register.
- `in_rs1` in 2: source register for `a`.
- `in_rs2` in 2: source register for `b`.
- `ld_en` in 1: external register load strobe.
- `ld_addr` in 2: external load address.
- `ld_data` in 4: external load data.
- `alu_a` out 4: to ALU `a`.
- `alu_b` out 4: to ALU `b`.
- `alu_op` out 4: to ALU `opcode`.
- `alu_x` in 4: from ALU `x`.
- `alu_y` in 4: from ALU `y`.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts result.
- `res_x` out 4: captured ALU `x`.
- `res_y` out 4: captured ALU `y`.
- `flag_z` out 1: last retired `res_x == 0` (flags build only).
- `flag_c` out 1: last retired add/sub had `res_y != 0` (flags build only).

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE: `in_ready`=1. When `in_valid`=1, latch op, rd, rs1 and rs2, then go to EXEC.
  - EXEC: `alu_a`=rf[rs1], `alu_b`=rf[rs2] (combinational read of current rf), `alu_op`=latched op. Capture `alu_x`/`alu_y` into `res_x`/`res_y`, then go to WB.
  - WB: `out_valid`=1. `res_*` are held stable until `out_ready`=1. On that handshake edge, write rf[rd] ← `res_x`, update flags, and go to IDLE.
- `alu_a`, `alu_b` and `alu_op` are 0 outside EXEC.
- `in_ready` is 0 in EXEC and WB. Instructions presented then are not accepted and must be held by upstream.
- Flags:
  - `flag_z` updates on every retire.
  - `flag_c` updates only for op 14 or 15 and holds otherwise.
  - Op 15 with a < b gives `res_y`=4'hF, so `flag_c`=1 (borrow).
- External load: `ld_en` writes rf[`ld_addr`] ← `ld_data` in any state.
- Same-cycle writeback and external load to the same address: writeback wins.
- Same-cycle writeback and external load to different addresses: both are performed.
- An external load in the EXEC cycle to rs1/rs2 does not affect the operands in use (old value used); it is visible to later instructions.
- rd may equal rs1/rs2; operands are read before writeback.

## Timing
- Reset (synchronous, takes priority over all activity):
  - State IDLE, all rf entries 0.
  - `res_x`/`res_y`=0; `out_valid`=0, `in_ready`=1.
  - `alu_a`/`alu_b`/`alu_op`=0; flags=0.
- Reset asserted in EXEC or WB discards the in-flight instruction; no writeback occurs.
- Accept at edge N → EXEC during cycle N+1 → `out_valid`=1 from cycle N+2.
- With `out_ready` held high, retire is at edge N+2→N+3 and `in_ready`=1 in cycle N+3. Throughput is one instruction per 3 cycles.
- Stall: each cycle of `out_ready`=0 in WB adds one cycle; `res_*` do not change.
- The result of instruction k is readable as an operand by instruction k+1 (no hazard, due to serialisation).

## Configuration
- `ALU4_SEQ_FLAGS_EN` defined: `flag_z`/`flag_c` registers and update logic are present, as described above.
- `ALU4_SEQ_FLAGS_EN` undefined: flag registers are removed and `flag_z`/`flag_c` are tied to 0. All other behaviour is identical.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles → all outputs at reset values. Issue op 9 (OR) rs1=0 rs2=0 rd=3 → `res_x`=0, `flag_z`=1.
- Add with carry: load r1=9, r2=8; issue op 14 rd=0 rs1=1 rs2=2 → `out_valid` at N+2 with `res_x`=1, `res_y`=1; after retire r0=1, `flag_c`=1, `flag_z`=0.
- Subtract borrow: r1=3, r2=5, op 15 rd=1 → `res_x`=4'hE, `res_y`=4'hF, `flag_c`=1, r1=4'hE afterwards.
- Backpressure: `out_ready`=0 for 4 cycles in WB → `res_*` stable, `in_ready`=0 with `in_valid` held, no rf write. On release, writeback occurs and the next instruction is accepted one cycle later.
- Load collision: in the retire cycle of op 8 (AND) rd=2 with `res_x`=4'h4, drive `ld_en` to addr 2 with data 4'hA → r2=4'h4. Repeat with `ld_addr`=3 → r2=4'h4 and r3=4'hA.
- Reset mid-op: assert `rst` during EXEC of op 14 rd=0 → r0=0, `out_valid` never rises, FSM returns to IDLE. Run the flags checks both with and without `ALU4_SEQ_FLAGS_EN` (flags read 0 when undefined).

Source files
------------

// File: rtl/alu4_seq.sv
// Register-file sequencer feeding the 4-bit combinational ALU: fetch operands, capture, write back.
// Optional status flags are built when ALU4_SEQ_FLAGS_EN is defined.
module alu4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs1,
    input  logic [1:0] in_rs2,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [3:0] alu_x,
    input  logic [3:0] alu_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] res_x,
    output logic [3:0] res_y,
    output logic       flag_z,
    output logic       flag_c
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e     state_q, state_d;
    logic [3:0] rf_q [4];
    logic [3:0] op_q;
    logic [1:0] rd_q, rs1_q, rs2_q;
    logic [3:0] res_x_q, res_y_q;
    logic       accept, capture, retire;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_op    = 4'h0;
        accept    = 1'b0;
        capture   = 1'b0;
        retire    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_a   = rf_q[rs1_q];
                alu_b   = rf_q[rs2_q];
                alu_op  = op_q;
                capture = 1'b1;
                state_d = StWb;
            end
            StWb: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    retire  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q    <= '{default: 4'h0};
            op_q    <= 4'h0;
            rd_q    <= 2'd0;
            rs1_q   <= 2'd0;
            rs2_q   <= 2'd0;
            res_x_q <= 4'h0;
            res_y_q <= 4'h0;
        end else begin
            if (accept) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
            end
            if (capture) begin
                res_x_q <= alu_x;
                res_y_q <= alu_y;
            end
            if (ld_en) begin
                rf_q[ld_addr] <= ld_data;
            end
            // Later assignment wins, so writeback overrides a same-address external load.
            if (retire) begin
                rf_q[rd_q] <= res_x_q;
            end
        end
    end

    assign res_x = res_x_q;
    assign res_y = res_y_q;

`ifdef ALU4_SEQ_FLAGS_EN
    logic flag_z_q, flag_c_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (retire) begin
            flag_z_q <= (res_x_q == 4'h0);
            // Carry/borrow only meaningful for add (14) and sub (15).
            if (op_q >= 4'd14) begin
                flag_c_q <= (res_y_q != 4'h0);
            end
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu4_seq.sv
// Scoreboard bench for alu4_seq: directed scenarios then random traffic against a cycle-level
// reference model; a negedge monitor compares DUT outputs with queued expectations.
module tb_alu4_seq;

`ifdef ALU4_SEQ_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    logic       clk, rst, in_valid, in_ready, ld_en, out_valid, out_ready, flag_z, flag_c;
    logic [3:0] in_op, ld_data, alu_a, alu_b, alu_op, alu_x, alu_y, res_x, res_y;
    logic [1:0] in_rd, in_rs1, in_rs2, ld_addr;

    alu4_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_x(alu_x),
        .alu_y(alu_y), .out_valid(out_valid), .out_ready(out_ready), .res_x(res_x),
        .res_y(res_y), .flag_z(flag_z), .flag_c(flag_c)
    );

    // Behavioural stand-in for the downstream ALU: {y, x}.
    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [4:0] s;
        case (op)
            4'd8:    return {4'h0, a & b};
            4'd9:    return {4'h0, a | b};
            4'd14: begin
                s = {1'b0, a} + {1'b0, b};
                return {3'b000, s[4], s[3:0]};
            end
            4'd15:   return {(a < b) ? 4'hF : 4'h0, a - b};
            default: return {a + op, a ^ b ^ op};
        endcase
    endfunction

    assign {alu_y, alu_x} = alu_ref(alu_op, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a, b, op, x, y;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 1'b0;

    // Reference model state
    logic [3:0] mrf [4];
    bit         busy, res_zero, accepted, fz, fc;
    int         e = 0;
    int         acc = 0;
    exp_t       cur;
    logic [1:0] cur_rd;
    bit         exp_in_ready, exp_exec, exp_wb;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {3'b0, in_ready}, {3'b0, exp_in_ready});
            check("out_valid", {3'b0, out_valid}, {3'b0, exp_wb});
            if (exp_exec && sb.size() > 0) begin
                check("alu_a", alu_a, sb[0].a);
                check("alu_b", alu_b, sb[0].b);
                check("alu_op", alu_op, sb[0].op);
            end else if (!exp_exec) begin
                check("alu_a_idle", alu_a, 4'h0);
                check("alu_b_idle", alu_b, 4'h0);
                check("alu_op_idle", alu_op, 4'h0);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got res_x=%h with empty queue", res_x);
                end else begin
                    check("res_x", res_x, sb[0].x);
                    check("res_y", res_y, sb[0].y);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (res_zero) begin
                check("res_x_rst", res_x, 4'h0);
                check("res_y_rst", res_y, 4'h0);
            end
            check("flag_z", {3'b0, flag_z}, {3'b0, FlagsEn & fz});
            check("flag_c", {3'b0, flag_c}, {3'b0, FlagsEn & fc});
        end
    end

    // Drive one cycle of inputs, then advance the model across the clock edge.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic le,
                       input logic [1:0] la, input logic [3:0] ld, input logic ordy,
                       input logic r);
        bit idle_before, retire;
        logic [7:0] yx;
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        ld_en = le; ld_addr = la; ld_data = ld; out_ready = ordy; rst = r;
        @(posedge clk);
        #1;
        e++;
        accepted = 1'b0;
        if (r) begin
            for (int i = 0; i < 4; i++) mrf[i] = 4'h0;
            busy = 1'b0; fz = 1'b0; fc = 1'b0; res_zero = 1'b1;
            sb.delete();
        end else begin
            idle_before = !busy;
            retire = busy && (e >= acc + 2) && ordy;
            if (le) mrf[la] = ld;
            if (retire) begin
                mrf[cur_rd] = cur.x;
                fz = (cur.x == 4'h0);
                if (cur.op >= 4'd14) fc = (cur.y != 4'h0);
                busy = 1'b0;
            end
            if (idle_before && v) begin
                busy = 1'b1; acc = e; accepted = 1'b1; res_zero = 1'b0;
                cur.a = mrf[rs1]; cur.b = mrf[rs2]; cur.op = op; cur_rd = rd;
                yx = alu_ref(op, cur.a, cur.b);
                cur.x = yx[3:0]; cur.y = yx[7:4];
                sb.push_back(cur);
            end
        end
        exp_in_ready = !busy;
        exp_exec = busy && (e == acc);
        exp_wb = busy && (e >= acc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2);
        cyc(1, op, rd, rs1, rs2, 0, 0, 0, 1, 0);
        idle(2);
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        cyc(0, 0, 0, 0, 0, 1, a, d, 1, 0);
    endtask

    logic       rv, rle, rordy, rr;
    logic [3:0] rop, rld;
    logic [1:0] rrd, rrs1, rrs2, rla;

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        issue(4'd9, 2'd3, 2'd0, 2'd0);          // OR of zeros -> flag_z
        load(2'd1, 4'h9);
        load(2'd2, 4'h8);
        issue(4'd14, 2'd0, 2'd1, 2'd2);         // 9+8: x=1, y=1
        issue(4'd9, 2'd3, 2'd0, 2'd0);          // read back r0
        load(2'd1, 4'h3);
        load(2'd2, 4'h5);
        issue(4'd15, 2'd1, 2'd1, 2'd2);         // 3-5: borrow
        issue(4'd9, 2'd0, 2'd1, 2'd1);          // read back r1
        // Backpressure with next instruction held upstream.
        cyc(1, 4'd14, 2'd0, 2'd1, 2'd2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 4'd9, 2'd3, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        cyc(1, 4'd9, 2'd3, 2'd0, 2'd0, 0, 0, 0, 1, 0);
        cyc(1, 4'd9, 2'd3, 2'd0, 2'd0, 0, 0, 0, 1, 0);
        idle(3);
        // Writeback vs external load collisions.
        load(2'd1, 4'h4);
        load(2'd2, 4'h6);
        cyc(1, 4'd8, 2'd2, 2'd1, 2'd2, 0, 0, 0, 1, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1, 2'd2, 4'hA, 1, 0);
        issue(4'd9, 2'd0, 2'd2, 2'd2);
        cyc(1, 4'd8, 2'd2, 2'd1, 2'd2, 0, 0, 0, 1, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1, 2'd3, 4'hA, 1, 0);
        issue(4'd9, 2'd0, 2'd3, 2'd3);
        issue(4'd9, 2'd0, 2'd2, 2'd2);
        // Load during EXEC must not alter operands in use.
        cyc(1, 4'd14, 2'd0, 2'd1, 2'd2, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 2'd1, 4'hF, 1, 0);
        idle(1);
        issue(4'd9, 2'd3, 2'd1, 2'd1);
        // Reset during EXEC discards the instruction.
        load(2'd1, 4'h9);
        load(2'd2, 4'h8);
        cyc(1, 4'd14, 2'd0, 2'd1, 2'd2, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);
        issue(4'd9, 2'd3, 2'd0, 2'd0);
        // Random traffic.
        rv = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!(rv && !accepted)) begin
                rv = ($urandom_range(0, 1) == 1);
                rop = 4'($urandom); rrd = 2'($urandom);
                rrs1 = 2'($urandom); rrs2 = 2'($urandom);
            end
            rle = ($urandom_range(0, 9) < 3);
            rla = 2'($urandom); rld = 4'($urandom);
            rordy = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 49) == 0);
            cyc(rv, rop, rrd, rrs1, rrs2, rle, rla, rld, rordy, rr);
            if (rr) rv = 1'b0;
        end
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
